mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_timeout.sv | 36 +++
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared types and sizing for the byte-serial memory controller.
//   memStateT : controller FSM state encoding
//   BEATS     : byte beats per 32-bit word
//   EXT_W     : external data bus width
//   BEAT_W    : width of the beat index
package mem_ctrl_pkg;

    localparam int BEATS  = 4;
    localparam int EXT_W  = 8;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } memStateT;

endpackage

// File: rtl/mem_timeout.sv
// mem_timeout -- per-beat watchdog for the external bus.
// Present in the build only when MEM_CTRL_TIMEOUT_EN is defined.
// Down-counter reloaded while the bus is idle or a beat completes; counts
// down on every ExtReady-low cycle of an active transfer.
//   Clock, nReset : clock, async active-low reset
//   active        : controller is in READ or WRITE
//   extReady      : external beat completion
//   expired       : this cycle is the TIMEOUT_CYCLES-th consecutive low cycle
module mem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic Clock,
    input  logic nReset,
    input  logic active,
    input  logic extReady,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            remaining <= CNT_W'(TIMEOUT_CYCLES);
        end else if (!active || extReady) begin
            remaining <= CNT_W'(TIMEOUT_CYCLES);
        end else if (remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Terminal count at 1: the cycle that would bring the count to zero is
    // the last low cycle tolerated, so the abort is taken at its edge.
    assign expired = active && !extReady && (remaining == CNT_W'(1));

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl -- turns 32-bit pipeline loads/stores into four little-endian
// byte beats on an 8-bit external bus with a ready handshake.
// Optional feature: define MEM_CTRL_TIMEOUT_EN to abort a beat after
// TIMEOUT_CYCLES consecutive ExtReady-low cycles (reported on MemError).
//   Clock, nReset        : clock, async active-low reset
//   MemRead, MemWrite    : pipeline request, held while MemStall is high
//   MemAddr, MemDataIn   : word address (bits [1:0] ignored), store data
//   MemDataOut           : registered load data
//   MemStall, MemError   : pipeline stall, one-cycle abort pulse
//   ExtAddr, ExtDataOut  : external byte address and write byte
//   ExtDataIn            : external read byte
//   ExtOE, ExtWE         : external read / write strobes
//   ExtReady             : external beat completion
//
// state | meaning
// IDLE  | waiting for a request; latches address/data when one arrives
// READ  | fetching bytes, one per ExtReady
// WRITE | storing bytes, one per ExtReady
// DONE  | single release cycle, requests ignored
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [15:0]      MemAddr,
    input  logic [31:0]      MemDataIn,
    output logic [31:0]      MemDataOut,
    output logic             MemStall,
    output logic             MemError,
    output logic [15:0]      ExtAddr,
    output logic [EXT_W-1:0] ExtDataOut,
    input  logic [EXT_W-1:0] ExtDataIn,
    output logic             ExtOE,
    output logic             ExtWE,
    input  logic             ExtReady
);
    memStateT          state;
    memStateT          nextState;
    logic [BEAT_W-1:0] beat;
    logic [13:0]       addrLat;
    logic [31:0]       dataLat;
    logic [31:0]       rdBuf;
    logic              inXfer;
    logic              lastBeat;
    logic              timeoutHit;
    logic              unusedSink;

    assign inXfer   = (state == READ) || (state == WRITE);
    assign lastBeat = (beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        ExtOE      = 1'b0;
        ExtWE      = 1'b0;
        ExtAddr    = '0;
        ExtDataOut = '0;
        MemStall   = 1'b0;
        case (state)
            IDLE: begin
                // Write has priority when both requests are raised together.
                if (MemWrite) begin
                    nextState = WRITE;
                end else if (MemRead) begin
                    nextState = READ;
                end
                // Gated by reset so the pipeline is never stalled during it.
                MemStall = nReset && (MemRead || MemWrite);
            end
            READ, WRITE: begin
                if ((ExtReady && lastBeat) || timeoutHit) begin
                    nextState = DONE;
                end
                MemStall = 1'b1;
                ExtOE    = (state == READ);
                ExtWE    = (state == WRITE);
                ExtAddr  = {addrLat, beat};
                if (state == WRITE) begin
                    ExtDataOut = dataLat[{beat, 3'b000} +: EXT_W];
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            beat       <= '0;
            addrLat    <= '0;
            dataLat    <= '0;
            rdBuf      <= '0;
            MemDataOut <= '0;
        end else if (state == IDLE) begin
            if (nextState != IDLE) begin
                addrLat <= MemAddr[15:2];
                dataLat <= MemDataIn;
                beat    <= '0;
            end
        end else if (inXfer && ExtReady) begin
            if (state == READ) begin
                rdBuf[{beat, 3'b000} +: EXT_W] <= ExtDataIn;
            end
            if (lastBeat) begin
                beat <= '0;
                // The final byte arrives on this edge, so merge it directly
                // rather than waiting a cycle for rdBuf.
                if (state == READ) begin
                    MemDataOut <= {ExtDataIn, rdBuf[3*EXT_W-1:0]};
                end
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    logic errPulse;

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeout (
        .Clock   (Clock),
        .nReset  (nReset),
        .active  (inXfer),
        .extReady(ExtReady),
        .expired (timeoutHit)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            errPulse <= 1'b0;
        end else begin
            errPulse <= timeoutHit;
        end
    end

    assign MemError = errPulse;
`else
    assign timeoutHit = 1'b0;
    assign MemError   = 1'b0;
`endif

    // Byte-offset bits are ignored; TIMEOUT_CYCLES is idle without the watchdog.
    assign unusedSink = ^{MemAddr[1:0], 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int TO = 4;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemAddr;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        MemStall;
    logic        MemError;
    logic [15:0] ExtAddr;
    logic [7:0]  ExtDataOut;
    logic [7:0]  ExtDataIn;
    logic        ExtOE;
    logic        ExtWE;
    logic        ExtReady;

    logic [7:0]  extMem [0:1023];

    always #5 Clock = ~Clock;

    assign ExtDataIn = extMem[ExtAddr[9:0]];

    mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemDataIn (MemDataIn),
        .MemDataOut(MemDataOut),
        .MemStall  (MemStall),
        .MemError  (MemError),
        .ExtAddr   (ExtAddr),
        .ExtDataOut(ExtDataOut),
        .ExtDataIn (ExtDataIn),
        .ExtOE     (ExtOE),
        .ExtWE     (ExtWE),
        .ExtReady  (ExtReady)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          lowBeat;
        int          lowCycles;
        logic        expErr;
        logic [31:0] expRdata;
    } vecT;

    typedef struct {
        int          doneCycle;
        logic [31:0] data;
        logic        err;
    } expT;

    vecT         vecs[$];
    expT         sb[$];
    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] lastRead = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // External device: commits the write byte at the coming rising edge.
    task automatic devCommit();
        if (ExtWE === 1'b1 && ExtReady === 1'b1) begin
            extMem[ExtAddr[9:0]] = ExtDataOut;
        end
    endtask

    task automatic runVec(input vecT v, input int idx);
        int          doneCyc;
        int          b;
        int          a;
        logic        isRd;
        logic        inX;
        logic        prevXfer;
        logic [15:0] base;
        expT         e;
        isRd     = v.rd && !v.wr;
        base     = {v.addr[15:2], 2'b00};
        doneCyc  = v.expErr ? (1 + v.lowBeat + TO) : (5 + v.lowCycles);
        prevXfer = 1'b0;
        for (int c = 0; c <= doneCyc + 1; c++) begin
            @(negedge Clock);
            MemRead   = v.rd && (c < doneCyc);
            MemWrite  = v.wr && (c < doneCyc);
            MemAddr   = v.addr;
            MemDataIn = v.wdata;
            ExtReady  = !((c - 1) >= v.lowBeat && (c - 1) < v.lowBeat + v.lowCycles);
            if (c == 0) begin
                e.doneCycle = doneCyc;
                e.data      = (isRd && !v.expErr) ? v.expRdata : lastRead;
                e.err       = v.expErr;
                sb.push_back(e);
            end
            #1;
            inX = (c >= 1) && (c < doneCyc);
            if (c - 1 < v.lowBeat) b = c - 1;
            else if (c - 1 < v.lowBeat + v.lowCycles) b = v.lowBeat;
            else b = c - 1 - v.lowCycles;
            check($sformatf("v%0d c%0d stall", idx, c), 32'(MemStall), 32'(c < doneCyc));
            check($sformatf("v%0d c%0d oe", idx, c), 32'(ExtOE), 32'(inX && isRd));
            check($sformatf("v%0d c%0d we", idx, c), 32'(ExtWE), 32'(inX && v.wr));
            if (inX) begin
                check($sformatf("v%0d c%0d extaddr", idx, c), 32'(ExtAddr), 32'(base) + 32'(b));
                if (v.wr) begin
                    check($sformatf("v%0d c%0d wbyte", idx, c), 32'(ExtDataOut),
                          (v.wdata >> (8 * b)) & 32'hFF);
                end
            end
            if (prevXfer && !ExtOE && !ExtWE) begin
                check($sformatf("v%0d done pending", idx), 32'(sb.size()), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check($sformatf("v%0d done cycle", idx), 32'(c), 32'(e.doneCycle));
                    check($sformatf("v%0d rdata", idx), MemDataOut, e.data);
                    check($sformatf("v%0d error", idx), 32'(MemError), 32'(e.err));
                    lastRead = e.data;
                end
            end else begin
                check($sformatf("v%0d c%0d error idle", idx, c), 32'(MemError), 32'd0);
                check($sformatf("v%0d c%0d rdata hold", idx, c), MemDataOut, lastRead);
            end
            prevXfer = ExtOE || ExtWE;
            devCommit();
        end
        check($sformatf("v%0d done seen in budget", idx), 32'(sb.size()), 32'd0);
        sb.delete();
        if (v.wr && !v.expErr) begin
            a = int'(base[9:0]);
            check($sformatf("v%0d ext memory", idx),
                  {extMem[a+3], extMem[a+2], extMem[a+1], extMem[a]}, v.wdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) extMem[i] = 8'h00;
        extMem[10'h104] = 8'h11;
        extMem[10'h105] = 8'h22;
        extMem[10'h106] = 8'h33;
        extMem[10'h107] = 8'h44;

        vecs.push_back('{1'b1, 1'b0, 16'h0104, 32'h0,        0, 0, 1'b0, 32'h44332211});
        vecs.push_back('{1'b0, 1'b1, 16'h0203, 32'hA1B2C3D4, 0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0200, 32'h0,        2, 3, 1'b0, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 1'b1, 16'h0300, 32'h55667788, 0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0302, 32'h0,        0, 1, 1'b0, 32'h55667788});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFE, 32'hDEADBEEF, 3, 2, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFD, 32'h0,        3, 2, 1'b0, 32'hDEADBEEF});
`ifdef MEM_CTRL_TIMEOUT_EN
        vecs.push_back('{1'b1, 1'b0, 16'h0104, 32'h0,        0, 1000, 1'b1, 32'h0});
`else
        vecs.push_back('{1'b1, 1'b0, 16'h0104, 32'h0,        1, 10, 1'b0, 32'h44332211});
`endif

        // Reset with a request already pending: everything quiet, no stall.
        nReset    = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        MemAddr   = 16'h0104;
        MemDataIn = 32'h0;
        ExtReady  = 1'b1;
        #1 nReset = 1'b0;
        #2;
        check("reset stall", 32'(MemStall), 32'd0);
        check("reset oe", 32'(ExtOE), 32'd0);
        check("reset we", 32'(ExtWE), 32'd0);
        check("reset extaddr", 32'(ExtAddr), 32'd0);
        check("reset wbyte", 32'(ExtDataOut), 32'd0);
        check("reset rdata", MemDataOut, 32'd0);
        check("reset error", 32'(MemError), 32'd0);
        @(negedge Clock);
        MemRead = 1'b0;
        nReset  = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], i);
        end

        // Reset during beat 1 of a write abandons it immediately.
        @(negedge Clock);
        MemWrite  = 1'b1;
        MemAddr   = 16'h0380;
        MemDataIn = 32'h01020304;
        ExtReady  = 1'b1;
        #1 devCommit();
        @(negedge Clock);
        #1;
        check("abort beat0 we", 32'(ExtWE), 32'd1);
        check("abort beat0 addr", 32'(ExtAddr), 32'h0380);
        devCommit();
        @(negedge Clock);
        #1;
        check("abort beat1 addr", 32'(ExtAddr), 32'h0381);
        nReset = 1'b0;
        #1;
        check("abort we", 32'(ExtWE), 32'd0);
        check("abort oe", 32'(ExtOE), 32'd0);
        check("abort stall", 32'(MemStall), 32'd0);
        check("abort extaddr", 32'(ExtAddr), 32'd0);
        check("abort wbyte", 32'(ExtDataOut), 32'd0);
        check("abort rdata", MemDataOut, 32'd0);
        check("abort error", 32'(MemError), 32'd0);
        MemWrite = 1'b0;
        lastRead = 32'h0;
        @(negedge Clock);
        nReset = 1'b1;
        check("abort byte0 kept", 32'(extMem[10'h380]), 32'h04);
        check("abort byte1 absent", 32'(extMem[10'h381]), 32'h00);

        runVec('{1'b1, 1'b0, 16'h0104, 32'h0, 0, 0, 1'b0, 32'h44332211}, 100);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
